// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Cache-to-memory line interface. The cache (master) raises MEM_ren or
//   MEM_wen together with MEM_addr/MEM_wdata and holds them until it sees
//   the one-cycle MEM_ready pulse from the memory (slave).
//
//   MEM_ren    master -> slave   read request
//   MEM_wen    master -> slave   write request
//   MEM_addr   master -> slave   line address
//   MEM_wdata  master -> slave   write line data
//   MEM_ready  slave  -> master  one-cycle completion pulse
//   MEM_rdata  slave  -> master  read line data, valid with MEM_ready
interface mem_responder_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 256
);
    logic              MEM_ren;
    logic              MEM_wen;
    logic [ADDR_W-1:0] MEM_addr;
    logic [DATA_W-1:0] MEM_wdata;
    logic              MEM_ready;
    logic [DATA_W-1:0] MEM_rdata;

    modport master (
        output MEM_ren, MEM_wen, MEM_addr, MEM_wdata,
        input  MEM_ready, MEM_rdata
    );

    modport slave (
        input  MEM_ren, MEM_wen, MEM_addr, MEM_wdata,
        output MEM_ready, MEM_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Backing memory for the cache line interface. Holds 2^DEPTH_LOG2 lines
//   and answers every accepted request with a single MEM_ready pulse in the
//   LATENCY-th cycle after the accept edge. One transaction in flight.
//
//   clk_i    clock, rising edge
//   start_i  asynchronous active-low reset (0 = reset, 1 = run)
//   mem      slave side of the line interface
//   err_o    sticky flag: a request arrived with MEM_ren and MEM_wen both high
//
//   state | meaning
//   IDLE  | waiting for MEM_ren|MEM_wen; request is captured on accept
//   BUSY  | latency down-counter running; request inputs ignored
//   RESP  | MEM_ready high for this cycle; writes commit at the closing edge
module mem_responder #(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 256
) (
    input  logic             clk_i,
    input  logic             start_i,
    mem_responder_if.slave   mem,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam bit         LAT_ONE  = (LATENCY == 1);
    // BUSY occupies LATENCY-1 cycles; the accept cycle itself is the first.
    localparam logic [7:0] CNT_LOAD = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    logic [DATA_W-1:0]     mem_q [DEPTH];

    state_t                state;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  wr_q;
    logic                  ready_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    logic                  req;
    logic [DEPTH_LOG2-1:0] idx_in;

    assign req    = mem.MEM_ren | mem.MEM_wen;
    assign idx_in = mem.MEM_addr[DEPTH_LOG2-1:0];

    // Upper address bits alias onto the same line by design.
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem.MEM_addr[ADDR_W-1:DEPTH_LOG2];
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx_in;
                        wdata_q <= mem.MEM_wdata;
                        wr_q    <= mem.MEM_wen;
                        if (mem.MEM_ren && mem.MEM_wen) begin
                            err_q <= 1'b1;
                        end
                        if (LAT_ONE) begin
                            // Straight to RESP: read the array with the live address.
                            state   <= RESP;
                            ready_q <= 1'b1;
                            if (!mem.MEM_wen) begin
                                rdata_q <= mem_q[idx_in];
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commit at the edge closing RESP, so a read accepted next sees new data.
    // start_i gating keeps an edge coincident with reset from committing.
    always_ff @(posedge clk_i) begin
        if (start_i && (state == RESP) && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem.MEM_ready = ready_q;
    assign mem.MEM_rdata = rdata_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int AW = 27;
    localparam int DW = 256;

    typedef struct {
        int          rdy_cyc;
        bit          is_read;
        bit          known;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic start_i = 1'b0;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    logic [1:0]    ren = '0;
    logic [1:0]    wen = '0;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    rdy;
    logic [DW-1:0] rd    [2];
    logic          err8;
    logic          err1;

    // Reference model: plain array of lines indexed by address modulo depth.
    logic [DW-1:0] mm [2][256];
    bit            mk [2][256];
    int            free_cyc [2];
    bit            err_exp  [2];
    logic [DW-1:0] last_rd  [2];
    bit            last_ok  [2];
    int            pulse_cnt[2];
    int            lat_of   [2];

    exp_t sb0[$];
    exp_t sb1[$];

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if8 ();
    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if8.MEM_ren   = ren[0];
    assign if8.MEM_wen   = wen[0];
    assign if8.MEM_addr  = addr[0];
    assign if8.MEM_wdata = wdata[0];
    assign if1.MEM_ren   = ren[1];
    assign if1.MEM_wen   = wen[1];
    assign if1.MEM_addr  = addr[1];
    assign if1.MEM_wdata = wdata[1];
    assign rdy[0] = if8.MEM_ready;
    assign rdy[1] = if1.MEM_ready;
    assign rd[0]  = if8.MEM_rdata;
    assign rd[1]  = if1.MEM_rdata;

    mem_responder #(.LATENCY(8), .DEPTH_LOG2(8), .ADDR_W(AW), .DATA_W(DW)) u_dut8 (
        .clk_i   (clk),
        .start_i (start_i),
        .mem     (if8.slave),
        .err_o   (err8)
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(8), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
        .clk_i   (clk),
        .start_i (start_i),
        .mem     (if1.slave),
        .err_o   (err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s[L%0d] @cyc %0d: got %0h expected %0h", nm, lat_of[i], cyc, act, exp_v);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (rdy[i]) begin
            pulse_cnt[i]++;
            if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            if (!have) begin
                chk("unexpected_ready", i, DW'(rdy[i]), '0);
            end else begin
                chk("ready_cycle", i, DW'(cyc), DW'(e.rdy_cyc));
                if (e.is_read) begin
                    if (e.known) chk("read_data", i, rd[i], e.data);
                    last_rd[i] = e.data;
                    last_ok[i] = e.known;
                end else if (last_ok[i]) begin
                    chk("rdata_hold_on_write", i, rd[i], last_rd[i]);
                end
            end
        end else if (last_ok[i]) begin
            chk("rdata_hold", i, rd[i], last_rd[i]);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Issue one request at the current negedge and hold it until MEM_ready.
    task automatic xact(input int i, input bit rd_op, input bit both,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
        exp_t e;
        int   acc;
        int   idx;
        bit   got;
        acc = (cyc + 1 > free_cyc[i]) ? cyc + 1 : free_cyc[i];
        idx = int'(a) % 256;
        ren[i]   = rd_op | both;
        wen[i]   = ~rd_op | both;
        addr[i]  = a;
        wdata[i] = d;
        e.rdy_cyc = acc + lat_of[i] - 1;
        e.is_read = rd_op && !both;
        e.known   = mk[i][idx];
        e.data    = mm[i][idx];
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
        got = 1'b0;
        for (int k = 0; k < lat_of[i] + 4; k++) begin
            @(negedge clk);
            if (drop && cyc >= acc) begin
                ren[i] = 1'b0;
                wen[i] = 1'b0;
            end
            if (rdy[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("ready_timeout", i, '0, DW'(1));
        end else begin
            free_cyc[i] = cyc + 2;
            if (!rd_op || both) begin
                mm[i][idx] = d;
                mk[i][idx] = 1'b1;
            end
            if (both) err_exp[i] = 1'b1;
        end
        ren[i] = 1'b0;
        wen[i] = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_run(input int i, input int n);
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = AW'($urandom_range(0, 7)) | (AW'($urandom_range(0, 3)) << 8);
            xact(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), a,
                 rand_line(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat;
        int acc;
        int snap;

        lat_of[0] = 8;
        lat_of[1] = 1;
        for (int i = 0; i < 2; i++) begin
            addr[i]      = '0;
            wdata[i]     = '0;
            free_cyc[i]  = 0;
            err_exp[i]   = 1'b0;
            last_rd[i]   = '0;
            last_ok[i]   = 1'b0;
            pulse_cnt[i] = 0;
        end

        // Reset held for 3 cycles, then idle with no requests.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start_i = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    last_rd[i] = '0;
                    last_ok[i] = 1'b1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                chk("reset_ready", i, DW'(rdy[i]), '0);
                chk("reset_rdata", i, rd[i], '0);
            end
            chk("reset_err", 0, DW'(err8), '0);
            chk("reset_err", 1, DW'(err1), '0);
        end

        // LATENCY=8 directed: write/read, aliasing, simultaneous ren+wen.
        pat = {32{8'hA5}};
        xact(0, 1'b0, 1'b0, 27'd5, pat, 1'b0);
        repeat (2) @(negedge clk);
        xact(0, 1'b1, 1'b0, 27'd5, '0, 1'b0);
        xact(0, 1'b0, 1'b0, 27'h100, {8{32'hC0FFEE01}}, 1'b0);
        xact(0, 1'b1, 1'b0, 27'h000, '0, 1'b0);
        xact(0, 1'b1, 1'b1, 27'd7, DW'(16'h1234), 1'b0);
        chk("err_sticky_set", 0, DW'(err8), DW'(err_exp[0]));
        @(negedge clk);
        xact(0, 1'b1, 1'b0, 27'd7, '0, 1'b1);
        chk("err_sticky_hold", 0, DW'(err8), DW'(err_exp[0]));

        // LATENCY=1 directed: fill 1..3 then back-to-back held reads.
        for (int a = 1; a <= 3; a++) xact(1, 1'b0, 1'b0, AW'(a), {8{32'(a * 32'h11111111)}}, 1'b0);
        for (int a = 1; a <= 3; a++) xact(1, 1'b1, 1'b0, AW'(a), '0, 1'b0);
        chk("err_clear_l1", 1, DW'(err1), DW'(err_exp[1]));

        // Randomized traffic on both instances concurrently.
        fork
            rand_run(0, 30);
            rand_run(1, 80);
        join
        @(negedge clk);
        chk("err_after_random", 0, DW'(err8), DW'(err_exp[0]));
        chk("err_after_random", 1, DW'(err1), DW'(err_exp[1]));

        // Reset during BUSY: write to line 5 aborted three cycles after accept.
        repeat (2) @(negedge clk);
        acc = cyc + 1;
        wen[0]   = 1'b1;
        addr[0]  = 27'd5;
        wdata[0] = {8{32'hDEADBEEF}};
        for (int k = 0; k < 6 && cyc < acc + 3; k++) @(negedge clk);
        last_ok[0] = 1'b0;
        last_ok[1] = 1'b0;
        start_i = 1'b0;
        snap = pulse_cnt[0];
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        wen[0]  = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_rd[i]  = '0;
            last_ok[i]  = 1'b1;
            free_cyc[i] = 0;
            err_exp[i]  = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("no_ready_after_abort", 0, DW'(pulse_cnt[0] - snap), '0);
        chk("err_after_reset", 0, DW'(err8), DW'(err_exp[0]));
        chk("err_after_reset", 1, DW'(err1), DW'(err_exp[1]));
        xact(0, 1'b1, 1'b0, 27'd5, '0, 1'b0);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 0, DW'(sb0.size()), '0);
        chk("scoreboard_drained", 1, DW'(sb1.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the cache's 256-bit line interface (MEM_ren/MEM_wen/MEM_addr/MEM_wdata in, MEM_ready/MEM_rdata out). It is the slave end of the protocol the cache initiates on a miss or write-back. It stores 2^DEPTH_LOG2 lines and answers each accepted request with a single-cycle MEM_ready pulse after a programmable latency. It is used as the synthesizable backing memory in CPU-level integration and as the reference responder in cache verification.

Parameters:
LATENCY, 8, cycles from request-accept edge to MEM_ready high; legal range 1..255
DEPTH_LOG2, 8, log2 of number of stored 256-bit lines
ADDR_W, 27, line-address width
DATA_W, 256, line width in bits

Ports:
clk_i  input  1  clock; all state updates on rising edge
start_i  input  1  reset, asynchronous, active-low (0 = reset, 1 = run)
MEM_ren  input  1  read request, held by the cache until MEM_ready
MEM_wen  input  1  write request, held by the cache until MEM_ready
MEM_addr  input  ADDR_W  line address
MEM_wdata  input  DATA_W  write line data
MEM_ready  output  1  one-cycle completion pulse
MEM_rdata  output  DATA_W  read line data, valid while MEM_ready is high
err_o  output  1  sticky protocol-error flag

Behaviour:
- Reset (start_i=0, asynchronous): state=IDLE, counter=0, MEM_ready=0, MEM_rdata=0, err_o=0. Line storage is not reset; contents are undefined until written.
- Reset mid-operation aborts the transaction. No write is committed and no ready pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE: a request is accepted on an edge where MEM_ren|MEM_wen=1. At accept, capture addr[DEPTH_LOG2-1:0], wdata, and op (write if MEM_wen, else read).
  - MEM_ren & MEM_wen both high: treat as a write and set err_o=1 (sticky until reset).
- Transition after accept:
  - LATENCY=1: go to RESP.
  - Otherwise: go to BUSY with counter=LATENCY-2.
- BUSY: decrement counter each cycle; at counter==0 go to RESP.
- MEM_ready is high for exactly one cycle, the LATENCY-th cycle after the accept edge.
- RESP: MEM_ready=1.
  - For a read, MEM_rdata is registered with the stored line on entry to RESP.
  - For a write, MEM_rdata holds its previous value, and the line is committed at the edge ending RESP.
  - Next state is always IDLE.
- Request inputs are ignored in BUSY and RESP; captured values are used.
  - A request dropped early still completes and pulses MEM_ready.
  - A request still high in the cycle after RESP is accepted as a new transaction.
- Minimum spacing between ready pulses is LATENCY+1 cycles.
- Read-after-write to the same line returns the new data, because the commit precedes the next accept.
- Address bits above DEPTH_LOG2 are ignored (aliasing); this is not flagged as an error.
- MEM_rdata holds its last read value outside ready pulses.
- Throughput: one outstanding transaction; no queueing.

Test Plan:
- Reset then idle: start_i=0 for 3 cycles then 1, no requests -> MEM_ready=0, MEM_rdata=0, err_o=0 throughout.
- Write then read, LATENCY=8: wen with addr=5, wdata=0xA5..A5 accepted at edge 0 -> ready high only in cycle 8; then ren addr=5 -> ready 8 cycles after its accept, MEM_rdata=0xA5..A5.
- LATENCY=1 back-to-back: reads to addr 1, 2, 3 held continuously -> ready every 2nd cycle, data matching prior writes.
- Simultaneous ren+wen, addr=7, wdata=0x1234 -> treated as a write, err_o=1 and stays 1; a later read of addr 7 returns 0x1234.
- Aliasing with DEPTH_LOG2=8: write addr=0x100 with data D, then read addr=0x000 -> returns D.
- Reset in BUSY: write accepted, start_i pulsed low at cycle 3 -> no ready pulse; a read of the same line does not return the new data.
